// File: rtl/on_chip_fsm_cam_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : on_chip_fsm_cam_pkg                                             |
// | Brief    : Shared types and constants for the camera frame writer.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package on_chip_fsm_cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  localparam int PIX_PER_WORD    = 4;
  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_FRAME_WORDS = 25600;

  // FIFO entry holds {address, byteenable, writedata}
  function automatic int fifo_entry_w(input int aw);
    return aw + PIX_PER_WORD + 32;
  endfunction

  // Byte-enable mask covering lanes 0..last_lane
  function automatic logic [3:0] lane_mask(input logic [1:0] last_lane);
    logic [3:0] m;
    case (last_lane)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/on_chip_fsm_cam_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : on_chip_fsm_cam_writer_if                                      |
// | Brief     : Avalon-MM write port between the frame writer and memory.      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface on_chip_fsm_cam_writer_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              mem_waitrequest;

  modport master (
    output address, byteenable, chipselect, write, writedata,
    input  mem_waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata,
    output mem_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/on_chip_fsm_cam_writer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_word_fifo                                                   |
// | Brief    : Small synchronous word FIFO, combinational head, push+pop on    |
// |            a full FIFO accepted because the pop frees the entry.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cam_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 51
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       push_i,
  input  wire logic [WIDTH-1:0]           push_data_i,
  input  wire logic                       pop_i,
  output logic      [WIDTH-1:0]           head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH):0]     count_o
);
  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw:0]    wr_ptr_q;
  logic [c_aw:0]    rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (count_o == (c_aw+1)'(DEPTH));
  assign empty_o   = (count_o == '0);
  assign head_o    = mem_q[rd_ptr_q[c_aw-1:0]];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, contents need no reset since empty gates the head
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[c_aw-1:0]] <= push_data_i;
  end
endmodule
`default_nettype wire

// File: rtl/on_chip_fsm_cam_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : on_chip_fsm_cam_writer                                          |
// | Brief    : Packs 8-bit camera pixels into 32-bit words and writes one      |
// |            frame per arm request into on-chip memory over Avalon-MM.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module on_chip_fsm_cam_writer
  import on_chip_fsm_cam_pkg::*;
#(
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              arm,
  input  wire logic              pix_valid,
  input  wire logic [7:0]        pix_data,
  input  wire logic              pix_sof,
  input  wire logic              pix_eof,
  on_chip_fsm_cam_writer_if.master avm,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow,
  output logic      [ADDR_W:0]   words_written
);
  localparam int                c_entry_w     = fifo_entry_w(ADDR_W);
  localparam int                c_cnt_w       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0]   c_frame_words = (ADDR_W+1)'(FRAME_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       pack_q, pack_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   ww_q, ww_d;

  logic                  w_take;
  logic [1:0]            w_lane;
  logic [ADDR_W:0]       w_cnt;
  logic [31:0]           w_word;
  logic                  w_push;
  logic [c_entry_w-1:0]  w_push_data;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [c_cnt_w-1:0]    w_count;
  logic [c_entry_w-1:0]  w_head;
  logic                  w_last;

  cam_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  assign w_pop  = ~w_empty & ~avm.mem_waitrequest;
  assign w_last = (w_count == c_cnt_w'(1));

  assign avm.chipselect = ~w_empty;
  assign avm.write      = ~w_empty;
  assign {avm.address, avm.byteenable, avm.writedata} = w_empty ? '0 : w_head;

  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = done_q;
  assign overflow      = ovf_q;
  assign words_written = ww_q;

  // Frame FSM, pixel packer and word counter next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    ww_d        = ww_q;
    w_take      = 1'b0;
    w_lane      = '0;
    w_cnt       = '0;
    w_word      = '0;
    w_push      = 1'b0;
    w_push_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_WAIT_SOF;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          lane_d  = '0;
          pack_d  = '0;
        end
      end
      ST_WAIT_SOF: w_take = pix_valid & pix_sof;
      ST_CAPTURE:  w_take = pix_valid;
      ST_DRAIN: begin
        // Leave on the edge that pops the final word so busy drops with frame_done
        if (w_empty || (w_last && w_pop)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ww_d    = cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_take) begin
      // A start-of-frame pixel always restarts packing at lane 0, word 0
      w_lane = pix_sof ? 2'd0 : lane_q;
      w_cnt  = pix_sof ? '0   : cnt_q;
      w_word = pix_sof ? '0   : pack_q;
      w_word[{w_lane, 3'b000} +: 8] = pix_data;

      if (w_lane == 2'd3 || pix_eof) begin
        lane_d      = '0;
        pack_d      = '0;
        w_push_data = {w_cnt[ADDR_W-1:0], lane_mask(w_lane), w_word};
        if (w_cnt == c_frame_words) begin
          ovf_d = 1'b1;
          cnt_d = w_cnt;
        end else begin
          // Counter advances even on a FIFO drop so later addresses stay aligned
          cnt_d = w_cnt + 1'b1;
          if (w_full && !w_pop) ovf_d  = 1'b1;
          else                  w_push = 1'b1;
        end
      end else begin
        lane_d = w_lane + 2'd1;
        pack_d = w_word;
        cnt_d  = w_cnt;
      end
      state_d = pix_eof ? ST_DRAIN : ST_CAPTURE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ww_q    <= ww_d;
    end
  end
endmodule
`default_nettype wire
